mux_scan_ctrl: RTL and testbench



---
 rtl/mux_scan_pkg.sv | 21 ++
 rtl/mux_scan_ctrl.sv | 144 ++++++++++++++
 tb/tb_mux_scan_ctrl.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/mux_scan_pkg.sv
// ============================================================================
// mux_scan_pkg : shared types and default sizes for the mux scan sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

package mux_scan_pkg;

  localparam int NUM_CH_DFLT = 16;
  localparam int SEL_W_DFLT  = 4;
  localparam int CNT_W       = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } scan_state_t;

endpackage : mux_scan_pkg

`default_nettype wire

// File: rtl/mux_scan_ctrl.sv
// ============================================================================
// mux_scan_ctrl : walks a 16:1 mux through every channel, samples y_i after a
// settle time and returns the assembled word over valid/ready.
// Optional: MUX_SCAN_PARITY_EN adds a registered result_parity output.
// Rev 1.0
// ============================================================================
`default_nettype none

module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int NUM_CH     = NUM_CH_DFLT,
  parameter int SEL_W      = SEL_W_DFLT,
  parameter int SETTLE_CYC = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [NUM_CH-1:0] mask,
  output logic [SEL_W-1:0]  sel_o,
  output logic              en_o,
  input  logic              y_i,
  output logic              busy,
  output logic [NUM_CH-1:0] result,
  output logic              result_valid,
`ifdef MUX_SCAN_PARITY_EN
  output logic              result_parity,
`endif
  input  logic              result_ready
);

  localparam logic [CNT_W-1:0] c_settle = CNT_W'(SETTLE_CYC);
  localparam logic [SEL_W-1:0] c_last   = SEL_W'(NUM_CH - 1);

  generate
    if (SEL_W != $clog2(NUM_CH)) begin : g_bad_sel_w
      $error("mux_scan_ctrl: SEL_W must equal log2(NUM_CH)");
    end
  endgenerate

  scan_state_t       r_state, w_state_nxt;
  logic [NUM_CH-1:0] r_mask, w_mask_nxt;
  logic [SEL_W-1:0]  r_idx, w_idx_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [NUM_CH-1:0] w_result_nxt;
  logic              w_valid_nxt;
  logic [SEL_W-1:0]  w_sel_nxt;
  logic              w_en_nxt;
  logic              w_busy_nxt;
`ifdef MUX_SCAN_PARITY_EN
  logic              w_parity_nxt;
`endif

  always_comb begin
    w_state_nxt  = r_state;
    w_mask_nxt   = r_mask;
    w_idx_nxt    = r_idx;
    w_cnt_nxt    = r_cnt;
    w_result_nxt = result;
    w_valid_nxt  = result_valid;
`ifdef MUX_SCAN_PARITY_EN
    w_parity_nxt = result_parity;
`endif

    case (r_state)
      IDLE: begin
        if (start) begin
          w_mask_nxt   = mask;
          w_result_nxt = '0;
          w_idx_nxt    = '0;
          w_cnt_nxt    = c_settle;
          w_state_nxt  = SCAN;
`ifdef MUX_SCAN_PARITY_EN
          w_parity_nxt = 1'b0;
`endif
        end
      end
      SCAN: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - 1'b1;
        end else begin
          w_result_nxt[r_idx] = r_mask[r_idx] & y_i;
          if (r_idx == c_last) begin
            w_state_nxt = DONE;
          end else begin
            w_idx_nxt = r_idx + 1'b1;
            w_cnt_nxt = c_settle;
          end
        end
      end
      DONE: begin
        // First DONE cycle raises valid; the word is complete by then.
        if (result_valid && result_ready) begin
          w_valid_nxt = 1'b0;
          w_state_nxt = IDLE;
        end else begin
          w_valid_nxt = 1'b1;
`ifdef MUX_SCAN_PARITY_EN
          w_parity_nxt = ^result;
`endif
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    // Mux drive is registered, so it is derived from the next-state values.
    w_sel_nxt  = (w_state_nxt == SCAN) ? w_idx_nxt : '0;
    w_en_nxt   = (w_state_nxt == SCAN) && w_mask_nxt[w_idx_nxt];
    w_busy_nxt = (w_state_nxt != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_mask       <= '0;
      r_idx        <= '0;
      r_cnt        <= '0;
      sel_o        <= '0;
      en_o         <= 1'b0;
      busy         <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
`ifdef MUX_SCAN_PARITY_EN
      result_parity <= 1'b0;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_mask       <= w_mask_nxt;
      r_idx        <= w_idx_nxt;
      r_cnt        <= w_cnt_nxt;
      sel_o        <= w_sel_nxt;
      en_o         <= w_en_nxt;
      busy         <= w_busy_nxt;
      result       <= w_result_nxt;
      result_valid <= w_valid_nxt;
`ifdef MUX_SCAN_PARITY_EN
      result_parity <= w_parity_nxt;
`endif
    end
  end

endmodule : mux_scan_ctrl

`default_nettype wire

// File: tb/tb_mux_scan_ctrl.sv
// ============================================================================
// tb_mux_scan_ctrl : randomized scoreboard bench for mux_scan_ctrl with a
// behavioural 16:1 mux loopback. Rev 1.0
// ============================================================================
`default_nettype none

module tb_mux_scan_ctrl;

  localparam int N = 16;
  localparam int S = 1;
  localparam int L = N * (S + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [N-1:0]  mask = '0;
  logic [3:0]    sel_o;
  logic          en_o;
  logic          y_i;
  logic          busy;
  logic [N-1:0]  result;
  logic          result_valid;
  logic          result_ready = 1'b0;
`ifdef MUX_SCAN_PARITY_EN
  logic          result_parity;
`endif
  logic [N-1:0]  data_in = '0;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int rdy_delay = 0;

  typedef struct {
    logic [N-1:0] res;
    int           cyc;
    logic         par;
  } exp_t;
  exp_t sb[$];

  mux_scan_ctrl #(.NUM_CH(N), .SEL_W(4), .SETTLE_CYC(S)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .mask         (mask),
    .sel_o        (sel_o),
    .en_o         (en_o),
    .y_i          (y_i),
    .busy         (busy),
    .result       (result),
    .result_valid (result_valid),
`ifdef MUX_SCAN_PARITY_EN
    .result_parity(result_parity),
`endif
    .result_ready (result_ready)
  );

  // Behavioural stand-in for mux16to1: disabled mux outputs 0.
  assign y_i = en_o ? data_in[sel_o] : 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Consumer: random ready while idle, programmable back-pressure once valid.
  int wait_cnt = 0;
  always @(posedge clk) begin
    #2;
    if (result_valid) begin
      result_ready = (wait_cnt >= rdy_delay);
      wait_cnt++;
    end else begin
      wait_cnt = 0;
      result_ready = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: pops the scoreboard when a result appears and follows the handshake.
  logic pv = 1'b0, pr = 1'b0, stable = 1'b1;
  exp_t cur;
  always @(negedge clk) begin
    if (rst) begin
      pv = 1'b0;
      pr = 1'b0;
    end else begin
      if (result_valid && !pv) begin
        if (sb.size() == 0) begin
          check("unexpected_valid", 32'(result_valid), 32'd0);
        end else begin
          cur = sb.pop_front();
          stable = 1'b1;
          check("result", 32'(result), 32'(cur.res));
          check("latency_cycle", 32'(cyc), 32'(cur.cyc));
          check("busy_in_done", 32'(busy), 32'd1);
`ifdef MUX_SCAN_PARITY_EN
          check("result_parity", 32'(result_parity), 32'(cur.par));
`endif
        end
      end else if (result_valid && result !== cur.res) begin
        stable = 1'b0;
      end
      if (pv && pr) begin
        check("idle_after_accept", {30'd0, result_valid, busy}, 32'd0);
        check("result_stable_while_valid", 32'(stable), 32'd1);
        check("result_kept_after_accept", 32'(result), 32'(cur.res));
      end else if (pv && !result_valid) begin
        check("valid_dropped_without_ready", 32'(result_valid), 32'd1);
      end
      pv = result_valid;
      pr = result_ready;
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("idle_timeout", 32'(busy), 32'd0);
  endtask

  // Issues one scan; abort_ch >= 0 pulses rst while that channel is selected.
  task automatic run_scan(input logic [N-1:0] data, input logic [N-1:0] msk,
                          input int delay, input int abort_ch);
    int bad = 0;
    int ign_k;
    int ch;
    logic [N-1:0] exp_res;
    wait_idle();
    data_in   = data;
    mask      = msk;
    rdy_delay = delay;
    start     = 1'b1;
    exp_res   = data & msk;
    if (abort_ch < 0) sb.push_back('{exp_res, cyc + 2 + L, ^exp_res});
    ign_k = $urandom_range(0, L - 2);
    for (int k = 0; k < L; k++) begin
      @(negedge clk);
      ch = k / (S + 1);
      if (abort_ch >= 0 && ch == abort_ch) begin
        start = 1'b0;
        check("sel_before_abort", 32'(sel_o), 32'(abort_ch));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_sel_en", {27'd0, sel_o, en_o}, 32'd0);
        check("abort_result", 32'(result), 32'd0);
        check("abort_valid_busy", {30'd0, result_valid, busy}, 32'd0);
        return;
      end
      if (sel_o !== 4'(ch) || en_o !== msk[ch] || busy !== 1'b1) bad++;
      // Late start pulses and mask churn must not disturb the scan.
      start = (k == ign_k);
      mask  = N'($urandom);
    end
    start = 1'b0;
    check("sel_en_walk_bad_cycles", 32'(bad), 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_outputs", {25'd0, sel_o, en_o, busy, result_valid}, 32'd0);
    check("reset_result", 32'(result), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_scan(16'hA5C3, 16'hFFFF, 0, -1);
    run_scan(16'hFFFF, 16'h00F0, 2, -1);
    run_scan(16'h5A3C, 16'hFFFF, 10, -1);
    run_scan(16'hFFFF, 16'hFFFF, 0, 7);
    run_scan(16'h1234, 16'hFFFF, 1, -1);
    run_scan(16'h8001, 16'hFFFF, 0, -1);
    run_scan(16'h0007, 16'hFFFF, 3, -1);
    run_scan(16'h0003, 16'hFFFF, 0, -1);
    run_scan(16'hFFFF, 16'h0000, 0, -1);

    for (int i = 0; i < 20; i++) begin
      run_scan(N'($urandom), ($urandom_range(0, 3) == 0) ? 16'hFFFF : N'($urandom),
               $urandom_range(0, 6), -1);
    end

    wait_idle();
    repeat (4) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule : tb_mux_scan_ctrl

`default_nettype wire
